// File: rtl/traffic_ctrl_np.sv
// Multi-phase signal controller: demand-driven round-robin phase selection,
// min/max green timing, fixed yellow and all-red clearance, emergency all-red.
module traffic_ctrl_np #(
  parameter int NPH       = 4,
  parameter int TW        = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic                     CK,
  input  logic                     RSTN,
  input  logic                     EN,
  input  logic [NPH-1:0]           REQ,
  input  logic                     EMG,
  output logic [NPH-1:0]           GREEN,
  output logic [NPH-1:0]           YELLOW,
  output logic [NPH-1:0]           RED,
  output logic [$clog2(NPH)-1:0]   PHASE,
  output logic [1:0]               STATE
);

  localparam int PW = $clog2(NPH);

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NPH-1:0]  ph_onehot;
  logic            other_req;
  logic [PW-1:0]   next_phase;
  logic [PW-1:0]   srch_idx;
  logic            found;

  assign ph_onehot = NPH'(1) << phase_q;
  assign other_req = |(REQ & ~ph_onehot);

  // Round-robin search starting after the current phase; current phase is checked last.
  always_comb begin
    next_phase = (phase_q == PW'(NPH - 1)) ? '0 : phase_q + PW'(1);
    found      = 1'b0;
    srch_idx   = '0;
    for (int i = 1; i <= NPH; i++) begin
      srch_idx = PW'((int'(phase_q) + i) % NPH);
      if (!found && REQ[srch_idx]) begin
        found      = 1'b1;
        next_phase = srch_idx;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_ALLRED;
      phase_q <= PW'(NPH - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    if (EN) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
      case (state_q)
        ST_ALLRED: begin
          // Emergency keeps the clearance interval at its start, so the full
          // all-red clearance runs again once the emergency drops.
          if (EMG) begin
            timer_d = '0;
          end else if (timer_q == T_AR) begin
            state_d = ST_GREEN;
            phase_d = next_phase;
            timer_d = '0;
          end
        end
        ST_GREEN: begin
          if (EMG ||
              (timer_q >= T_GMIN && other_req && !REQ[phase_q]) ||
              (timer_q >= T_GMAX && other_req)) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end
        end
        ST_YELLOW: begin
          if (timer_q == T_YEL) begin
            state_d = ST_ALLRED;
            timer_d = '0;
          end
        end
        default: begin
          state_d = ST_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    GREEN  = '0;
    YELLOW = '0;
    case (state_q)
      ST_GREEN:  GREEN  = ph_onehot;
      ST_YELLOW: YELLOW = ph_onehot;
      default: ;
    endcase
    RED   = ~(GREEN | YELLOW);
    PHASE = phase_q;
    STATE = state_q;
  end

endmodule

// File: tb/tb_traffic_ctrl_np.sv
// Table-driven bench for traffic_ctrl_np with default parameters (NPH=4):
// each row holds inputs, a repeat count and the outputs expected after every edge.
module tb_traffic_ctrl_np;

  logic       CK = 1'b0;
  logic       RSTN, EN, EMG;
  logic [3:0] REQ;
  logic [3:0] GREEN, YELLOW, RED;
  logic [1:0] PHASE, STATE;

  localparam logic [1:0] AR = 2'b00, GR = 2'b01, YE = 2'b10;

  typedef struct {
    logic       rstn;
    logic       en;
    logic [3:0] req;
    logic       emg;
    int         n;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] st;
    logic [1:0] ph;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  always #5 CK = ~CK;

  traffic_ctrl_np #(
    .NPH(4), .TW(8), .GREEN_MIN(8), .GREEN_MAX(32), .YELLOW_T(3), .ALLRED_T(2)
  ) dut (
    .CK(CK), .RSTN(RSTN), .EN(EN), .REQ(REQ), .EMG(EMG),
    .GREEN(GREEN), .YELLOW(YELLOW), .RED(RED), .PHASE(PHASE), .STATE(STATE)
  );

  task automatic add(input logic rstn, input logic en, input logic [3:0] req,
                     input logic emg, input int n, input logic [3:0] g,
                     input logic [3:0] y, input logic [1:0] st, input logic [1:0] ph);
    vec_t v;
    v.rstn = rstn; v.en = en; v.req = req; v.emg = emg; v.n = n;
    v.g = g; v.y = y; v.st = st; v.ph = ph;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [3:0] y,
                       input logic [1:0] st, input logic [1:0] ph);
    logic [3:0] r;
    r = ~(g | y);
    n_vec++;
    if (GREEN !== g || YELLOW !== y || RED !== r || STATE !== st || PHASE !== ph) begin
      n_err++;
      $display("FAIL %s: got G=%b Y=%b R=%b ST=%b PH=%0d, want G=%b Y=%b R=%b ST=%b PH=%0d",
               name, GREEN, YELLOW, RED, STATE, PHASE, g, y, r, st, ph);
    end
  endtask

  initial begin
    RSTN = 1'b0; EN = 1'b1; EMG = 1'b0; REQ = '0;

    // rstn en req emg n      G     Y     ST ph
    // Reset, first green with no demand, green rests
    add(0, 1, 4'b0000, 0,   2, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0000, 0, 100, 4'b0001, 4'b0000, GR, 2'd0);
    // Min-green exit to phase 2, phase 1 skipped
    add(0, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0100, 0,   7, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0100, 0,   3, 4'b0000, 4'b0001, YE, 2'd0);
    add(1, 1, 4'b0100, 0,   2, 4'b0000, 4'b0000, AR, 2'd0);
    add(1, 1, 4'b0100, 0,   1, 4'b0100, 4'b0000, GR, 2'd2);
    // Reset during GREEN=0100: no yellow
    add(0, 1, 4'b0100, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    // Max-green exit with own request still held
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0011, 0,  31, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0011, 0,   3, 4'b0000, 4'b0001, YE, 2'd0);
    add(1, 1, 4'b0011, 0,   2, 4'b0000, 4'b0000, AR, 2'd0);
    add(1, 1, 4'b0011, 0,   1, 4'b0010, 4'b0000, GR, 2'd1);
    // Emergency at cycle 3 of phase 1 green, held 10 cycles
    add(1, 1, 4'b0000, 0,   2, 4'b0010, 4'b0000, GR, 2'd1);
    add(1, 1, 4'b0000, 1,   3, 4'b0000, 4'b0010, YE, 2'd1);
    add(1, 1, 4'b0000, 1,   7, 4'b0000, 4'b0000, AR, 2'd1);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd1);
    add(1, 1, 4'b0000, 0,   1, 4'b0100, 4'b0000, GR, 2'd2);
    // EN=0 for 5 cycles mid-yellow
    add(1, 1, 4'b0000, 1,   1, 4'b0000, 4'b0100, YE, 2'd2);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0100, YE, 2'd2);
    add(1, 0, 4'b0000, 0,   5, 4'b0000, 4'b0100, YE, 2'd2);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0100, YE, 2'd2);
    add(1, 1, 4'b0000, 0,   2, 4'b0000, 4'b0000, AR, 2'd2);
    add(1, 1, 4'b0000, 0,   1, 4'b1000, 4'b0000, GR, 2'd3);
    // Phase wrap 3 -> 0
    add(1, 1, 4'b0000, 1,   1, 4'b0000, 4'b1000, YE, 2'd3);
    add(1, 1, 4'b0000, 0,   2, 4'b0000, 4'b1000, YE, 2'd3);
    add(1, 1, 4'b0000, 0,   2, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);
    // Only the current phase requests: it is chosen again, then rests
    add(1, 1, 4'b0001, 1,   1, 4'b0000, 4'b0001, YE, 2'd0);
    add(1, 1, 4'b0001, 0,   2, 4'b0000, 4'b0001, YE, 2'd0);
    add(1, 1, 4'b0001, 0,   2, 4'b0000, 4'b0000, AR, 2'd0);
    add(1, 1, 4'b0001, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);
    add(1, 1, 4'b0001, 0,  20, 4'b0001, 4'b0000, GR, 2'd0);
    // EN=0 freezes even against EMG; reset beats EN=0 and EMG
    add(1, 0, 4'b0000, 1,   3, 4'b0001, 4'b0000, GR, 2'd0);
    add(0, 0, 4'b0000, 1,   1, 4'b0000, 4'b0000, AR, 2'd3);
    // EMG held in all-red after reset, clearance runs after release
    add(1, 1, 4'b0000, 1,   4, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0000, 4'b0000, AR, 2'd3);
    add(1, 1, 4'b0000, 0,   1, 4'b0001, 4'b0000, GR, 2'd0);

    foreach (tbl[v]) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        @(negedge CK);
        RSTN = tbl[v].rstn; EN = tbl[v].en; REQ = tbl[v].req; EMG = tbl[v].emg;
        @(posedge CK);
        #1;
        check($sformatf("row%0d.%0d", v, k), tbl[v].g, tbl[v].y, tbl[v].st, tbl[v].ph);
      end
    end

    // Demand present from reset release: first green goes to the requesting phase
    @(negedge CK);
    RSTN = 1'b0; EN = 1'b1; EMG = 1'b0; REQ = 4'b0000;
    @(posedge CK);
    #1;
    check("reset_again", 4'b0000, 4'b0000, AR, 2'd3);
    @(negedge CK);
    RSTN = 1'b1; REQ = 4'b0100;
    cyc = 0;
    while (GREEN === 4'b0000 && cyc < 20) begin
      @(posedge CK);
      #1;
      cyc++;
    end
    n_vec++;
    if (cyc != 2) begin
      n_err++;
      $display("FAIL green_latency: got %0d cycles, want 2", cyc);
    end
    check("first_green_demand", 4'b0100, 4'b0000, GR, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
